sync_deb_gea1: RTL and testbench

- Generic input-conditioning cell.
- Takes one raw asynchronous pin-level signal, synchronizes it into the clk domain, and debounces it.
- Produces a clean level plus single-cycle rise and fall strobes.
- Sits directly upstream of the generic gate cells (nor2/nand2 family), so those gates only ever see stable, glitch-free, synchronous inputs.

---
 rtl/sync_deb_gea1_if.sv | 39 +++
 rtl/sync_deb_gea1.sv | 93 +++++++++
 tb/tb_sync_deb_gea1.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sync_deb_gea1_if.sv
// Input-conditioning bus for sync_deb_gea1: raw pin + sample tick in, clean level/strobes out.
// SYNC_DEB_GLITCH_CNT_EN adds the glitch_cnt field.
interface sync_deb_gea1_if;
   logic       a;
   logic       en;
   logic       y;
   logic       rise;
   logic       fall;
   logic       busy;
`ifdef SYNC_DEB_GLITCH_CNT_EN
   logic [7:0] glitch_cnt;
`endif

   // Driver side: supplies the raw pin and the sample tick.
   modport master (
      output a,
      output en,
      input  y,
      input  rise,
      input  fall,
`ifdef SYNC_DEB_GLITCH_CNT_EN
      input  glitch_cnt,
`endif
      input  busy
   );

   // Conditioning cell side.
   modport slave (
      input  a,
      input  en,
      output y,
      output rise,
      output fall,
`ifdef SYNC_DEB_GLITCH_CNT_EN
      output glitch_cnt,
`endif
      output busy
   );
endinterface

// File: rtl/sync_deb_gea1.sv
// Synchronizer + debouncer for one asynchronous pin. Produces a clean level and single-cycle
// rise/fall strobes. Optional macro SYNC_DEB_GLITCH_CNT_EN adds a saturating count of
// aborted debounce attempts.
module sync_deb_gea1 #(
   parameter int unsigned STAGES  = 2,
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned DEB_CNT = 10
) (
   input logic              clk,
   input logic              rst,
   sync_deb_gea1_if.slave   bus
);

   // Reject illegal configurations at elaboration.
   if (DEB_CNT < 1 || DEB_CNT > (2 ** CNT_W - 1)) begin : g_bad_deb_cnt
      $error("sync_deb_gea1: DEB_CNT out of range 1..2**CNT_W-1");
   end
   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("sync_deb_gea1: STAGES out of range 2..4");
   end

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CNT - 1);

   logic [STAGES-1:0] sync_q;
   logic              s;
   logic [CNT_W-1:0]  cnt_q;
   logic              y_q;
   logic              rise_q;
   logic              fall_q;
   logic              busy_q;

   assign s = sync_q[STAGES-1];

   // Synchronizer chain; shifts every cycle regardless of en.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], bus.a};
      end
   end

   // Debounce counter, committed level and strobes. A match of s with y always wins,
   // so a bounce back on the would-be commit cycle aborts instead of committing.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         y_q    <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (s == y_q) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
         end else if (bus.en) begin
            if (cnt_q == CntLast) begin
               y_q    <= s;
               cnt_q  <= '0;
               busy_q <= 1'b0;
               rise_q <= s;
               fall_q <= ~s;
            end else begin
               cnt_q  <= cnt_q + CNT_W'(1);
               busy_q <= 1'b1;
            end
         end
      end
   end

   assign bus.y    = y_q;
   assign bus.rise = rise_q;
   assign bus.fall = fall_q;
   assign bus.busy = busy_q;

`ifdef SYNC_DEB_GLITCH_CNT_EN
   logic [7:0] glitch_q;

   // Count aborted attempts (pending count cleared by s returning to y), saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         glitch_q <= 8'd0;
      end else if (cnt_q != '0 && s == y_q && glitch_q != 8'hFF) begin
         glitch_q <= glitch_q + 8'd1;
      end
   end

   assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sync_deb_gea1.sv
// Directed bench for sync_deb_gea1 (STAGES=2, CNT_W=4, DEB_CNT=4).
// Outputs are compared as the packed vector {y, rise, fall, busy}.
module tb_sync_deb_gea1;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   sync_deb_gea1_if bus ();

   sync_deb_gea1 #(
      .STAGES  (2),
      .CNT_W   (4),
      .DEB_CNT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observation against its expected value.
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {4'b0, bus.y, bus.rise, bus.fall, bus.busy};
   endfunction

   // Hold a at a_val and check 7 edges against a hand-computed table.
   task automatic seq7(input string tag, input logic a_val, input logic [3:0] e0,
                       input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3,
                       input logic [3:0] e4, input logic [3:0] e5, input logic [3:0] e6);
      logic [3:0] tbl [7];
      tbl = '{e0, e1, e2, e3, e4, e5, e6};
      bus.a = a_val;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("%s_e%0d", tag, i + 1), outs(), {4'b0, tbl[i]});
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst    = 1'b1;
      bus.a  = 1'b0;
      bus.en = 1'b1;
      tick();
      tick();
      chk("reset_outs", outs(), 8'h00);
      rst = 1'b0;

      // Quiet input: nothing moves.
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("idle_%0d", i), outs(), 8'h00);
      end

      // Clean rise: commit on edge 6, busy on edges 3..5.
      seq7("rise", 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000);

      // Clean fall.
      seq7("fall", 1'b0, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0000);

      // Two-cycle glitch high: counts twice, then aborts.
      bus.a = 1'b1;
      tick();
      chk("glitch_e1", outs(), 8'h00);
      tick();
      chk("glitch_e2", outs(), 8'h00);
      bus.a = 1'b0;
      tick();
      chk("glitch_e3", outs(), 8'h01);
      tick();
      chk("glitch_e4", outs(), 8'h01);
      tick();
      chk("glitch_e5", outs(), 8'h00);
      tick();
      chk("glitch_e6", outs(), 8'h00);
`ifdef SYNC_DEB_GLITCH_CNT_EN
      chk("glitch_cnt_1", bus.glitch_cnt, 8'd1);
`endif

      // en every 3rd cycle: counts on edges 3,6,9, commits on edge 12.
      bus.a = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         logic [3:0] e;
         bus.en = (i % 3 == 0);
         tick();
         e = {(i >= 12) ? 1'b1 : 1'b0, (i == 12) ? 1'b1 : 1'b0, 1'b0,
              (i >= 3 && i < 12) ? 1'b1 : 1'b0};
         chk($sformatf("en3_e%0d", i), outs(), {4'b0, e});
      end
      bus.en = 1'b1;

      // Reset while a fall is pending: y drops, no fall strobe.
      bus.a = 1'b0;
      tick();
      tick();
      tick();
      chk("rstbusy_pre", outs(), 8'h09);
      rst = 1'b1;
      tick();
      chk("rstbusy_rst", outs(), 8'h00);
      rst = 1'b0;
      tick();
      chk("rstbusy_post1", outs(), 8'h00);
      tick();
      chk("rstbusy_post2", outs(), 8'h00);

      // a high through reset: a full fresh debounce is needed afterwards.
      bus.a = 1'b1;
      rst   = 1'b1;
      tick();
      chk("rsthi_rst", outs(), 8'h00);
      rst = 1'b0;
      seq7("rsthi", 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000);

      // Bounce back on the would-be commit edge: no fall.
      bus.a = 1'b0;
      tick();
      chk("bounce_e1", outs(), 8'h08);
      tick();
      chk("bounce_e2", outs(), 8'h08);
      tick();
      chk("bounce_e3", outs(), 8'h09);
      bus.a = 1'b1;
      tick();
      chk("bounce_e4", outs(), 8'h09);
      tick();
      chk("bounce_e5", outs(), 8'h09);
      tick();
      chk("bounce_e6", outs(), 8'h08);
      tick();
      chk("bounce_e7", outs(), 8'h08);

`ifdef SYNC_DEB_GLITCH_CNT_EN
      // After the reset above only the bounce abort is counted.
      chk("glitch_cnt_bounce", bus.glitch_cnt, 8'd1);
      for (int g = 0; g < 300; g++) begin
         bus.a = 1'b0;
         tick();
         tick();
         bus.a = 1'b1;
         tick();
         tick();
         tick();
         tick();
      end
      chk("glitch_cnt_sat", bus.glitch_cnt, 8'd255);
      chk("glitch_sat_y", outs(), 8'h08);
      rst = 1'b1;
      tick();
      chk("glitch_cnt_rst", bus.glitch_cnt, 8'd0);
      rst = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
